// File: rtl/pwm_gate_monitor.sv
// Gate-pair timing monitor: measures period, per-phase high time and both dead times
// of the complementary c1/c2 pair, and flags shoot-through and loss of switching.
module pwm_gate_monitor #(
  parameter int unsigned CW      = 16,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic          i_c1,
  input  logic          i_c2,
  input  logic          i_clr,
  output logic          o_valid,
  output logic [CW-1:0] o_period,
  output logic [CW-1:0] o_t1,
  output logic [CW-1:0] o_t2,
  output logic [CW-1:0] o_dt1,
  output logic [CW-1:0] o_dt2,
  output logic          o_overlap,
  output logic          o_stall
);

  localparam logic [CW-1:0] CntMax = '1;

  typedef enum logic {StIdle, StRun} state_e;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CntMax) ? v : v + CW'(1);
  endfunction

  logic r_c1_s1, r_c1_s2, r_c1_prev;
  logic r_c2_s1, r_c2_s2, r_c2_prev;
  logic w_c1, w_c2, w_c1_rise, w_c2_rise;

  state_e        r_state, w_state;
  logic [CW-1:0] r_period_acc, w_period_acc;
  logic [CW-1:0] r_t1_acc, w_t1_acc;
  logic [CW-1:0] r_t2_acc, w_t2_acc;
  logic [CW-1:0] r_low_cnt, w_low_cnt;
  logic [CW-1:0] r_dt2_acc, w_dt2_acc;
  logic [CW-1:0] r_stall_cnt, w_stall_cnt;
  logic          r_valid, w_valid;
  logic [CW-1:0] r_period, w_period;
  logic [CW-1:0] r_t1, w_t1;
  logic [CW-1:0] r_t2, w_t2;
  logic [CW-1:0] r_dt1, w_dt1;
  logic [CW-1:0] r_dt2, w_dt2;
  logic          r_overlap, w_overlap;

  // Two-flop synchronizers plus a previous sample for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c1_s1   <= 1'b0;
      r_c1_s2   <= 1'b0;
      r_c1_prev <= 1'b0;
      r_c2_s1   <= 1'b0;
      r_c2_s2   <= 1'b0;
      r_c2_prev <= 1'b0;
    end else begin
      r_c1_s1   <= i_c1;
      r_c1_s2   <= r_c1_s1;
      r_c1_prev <= r_c1_s2;
      r_c2_s1   <= i_c2;
      r_c2_s2   <= r_c2_s1;
      r_c2_prev <= r_c2_s2;
    end
  end

  assign w_c1      = r_c1_s2;
  assign w_c2      = r_c2_s2;
  assign w_c1_rise = r_c1_s2 & ~r_c1_prev;
  assign w_c2_rise = r_c2_s2 & ~r_c2_prev;

  always_comb begin
    w_state      = r_state;
    w_period_acc = r_period_acc;
    w_t1_acc     = r_t1_acc;
    w_t2_acc     = r_t2_acc;
    w_low_cnt    = r_low_cnt;
    w_dt2_acc    = r_dt2_acc;
    w_stall_cnt  = r_stall_cnt;
    w_valid      = 1'b0;
    w_period     = r_period;
    w_t1         = r_t1;
    w_t2         = r_t2;
    w_dt1        = r_dt1;
    w_dt2        = r_dt2;

    if (!i_en) begin
      w_state      = StIdle;
      w_period_acc = '0;
      w_t1_acc     = '0;
      w_t2_acc     = '0;
      w_low_cnt    = '0;
      w_dt2_acc    = '0;
      w_stall_cnt  = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_period_acc = '0;
          w_t1_acc     = '0;
          w_t2_acc     = '0;
          w_low_cnt    = '0;
          w_dt2_acc    = '0;
          w_stall_cnt  = '0;
          if (w_c1_rise) begin
            w_state      = StRun;
            w_period_acc = CW'(1);
            w_t1_acc     = CW'(1);
            w_t2_acc     = CW'(w_c2);
          end
        end
        StRun: begin
          w_stall_cnt = sat_inc(r_stall_cnt);
          if (w_c1_rise) begin
            // Close the period; the rising cycle is cycle 1 of the next one
            w_valid      = 1'b1;
            w_period     = r_period_acc;
            w_t1         = r_t1_acc;
            w_t2         = r_t2_acc;
            w_dt1        = r_low_cnt;
            w_dt2        = w_c2_rise ? r_low_cnt : r_dt2_acc;
            w_period_acc = CW'(1);
            w_t1_acc     = CW'(1);
            w_t2_acc     = CW'(w_c2);
            w_low_cnt    = '0;
            w_dt2_acc    = '0;
            w_stall_cnt  = '0;
          end else begin
            w_period_acc = sat_inc(r_period_acc);
            if (w_c1) w_t1_acc = sat_inc(r_t1_acc);
            if (w_c2) w_t2_acc = sat_inc(r_t2_acc);
            if (w_c2_rise) begin
              w_dt2_acc = r_low_cnt;
              w_low_cnt = '0;
            end else if (!w_c1 && !w_c2) begin
              w_low_cnt = sat_inc(r_low_cnt);
            end
          end
        end
        default: w_state = StIdle;
      endcase
    end

    // Set wins over a simultaneous clear
    w_overlap = (i_en && w_c1 && w_c2) ? 1'b1 : (i_clr ? 1'b0 : r_overlap);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_period_acc <= '0;
      r_t1_acc     <= '0;
      r_t2_acc     <= '0;
      r_low_cnt    <= '0;
      r_dt2_acc    <= '0;
      r_stall_cnt  <= '0;
      r_valid      <= 1'b0;
      r_period     <= '0;
      r_t1         <= '0;
      r_t2         <= '0;
      r_dt1        <= '0;
      r_dt2        <= '0;
      r_overlap    <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_period_acc <= w_period_acc;
      r_t1_acc     <= w_t1_acc;
      r_t2_acc     <= w_t2_acc;
      r_low_cnt    <= w_low_cnt;
      r_dt2_acc    <= w_dt2_acc;
      r_stall_cnt  <= w_stall_cnt;
      r_valid      <= w_valid;
      r_period     <= w_period;
      r_t1         <= w_t1;
      r_t2         <= w_t2;
      r_dt1        <= w_dt1;
      r_dt2        <= w_dt2;
      r_overlap    <= w_overlap;
    end
  end

  assign o_valid   = r_valid;
  assign o_period  = r_period;
  assign o_t1      = r_t1;
  assign o_t2      = r_t2;
  assign o_dt1     = r_dt1;
  assign o_dt2     = r_dt2;
  assign o_overlap = r_overlap;
  assign o_stall   = (r_state == StRun) && (32'(r_stall_cnt) >= TIMEOUT);

endmodule

// File: tb/tb_pwm_gate_monitor.sv
// Scoreboard bench for pwm_gate_monitor: waveform periods push expected measurements,
// a negedge monitor pops and compares them when o_valid fires.
module tb_pwm_gate_monitor;

  localparam int CW      = 8;
  localparam int TIMEOUT = 50;
  localparam int MaxV    = (1 << CW) - 1;

  typedef struct {
    int period;
    int t1;
    int t2;
    int dt1;
    int dt2;
    int cyc;
  } exp_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_en  = 1'b0;
  logic          i_c1  = 1'b0;
  logic          i_c2  = 1'b0;
  logic          i_clr = 1'b0;
  logic          o_valid;
  logic [CW-1:0] o_period, o_t1, o_t2, o_dt1, o_dt2;
  logic          o_overlap, o_stall;

  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  exp_t pend;
  exp_t got;
  exp_t exp_last;
  bit   have_prev = 1'b0;

  pwm_gate_monitor #(
    .CW      (CW),
    .TIMEOUT (TIMEOUT)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (i_en),
    .i_c1      (i_c1),
    .i_c2      (i_c2),
    .i_clr     (i_clr),
    .o_valid   (o_valid),
    .o_period  (o_period),
    .o_t1      (o_t1),
    .o_t2      (o_t2),
    .o_dt1     (o_dt1),
    .o_dt2     (o_dt2),
    .o_overlap (o_overlap),
    .o_stall   (o_stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v);
    return (v > MaxV) ? MaxV : v;
  endfunction

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_phase(input logic c1, input logic c2, input int n);
    repeat (n) begin
      i_c1 = c1;
      i_c2 = c2;
      @(posedge clk);
      #1;
    end
  endtask

  // One period starting with a c1 rise; that rise closes the previous period
  task automatic run_period(input int a, input int b, input int c, input int d, input int ov);
    if (have_prev && i_en) begin
      pend.cyc = cyc + 3;
      sb_q.push_back(pend);
    end
    have_prev   = i_en;
    pend.period = sat(a + ov + b + c + d);
    pend.t1     = sat(a + ov);
    pend.t2     = sat(ov + c);
    pend.dt1    = sat(d);
    pend.dt2    = sat(b);
    drive_phase(1'b1, 1'b0, a);
    drive_phase(1'b1, 1'b1, ov);
    drive_phase(1'b0, 1'b0, b);
    drive_phase(1'b0, 1'b1, c);
    drive_phase(1'b0, 1'b0, d);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"},   o_valid,   0);
    check_eq({tag, "_period"},  o_period,  0);
    check_eq({tag, "_t1"},      o_t1,      0);
    check_eq({tag, "_t2"},      o_t2,      0);
    check_eq({tag, "_dt1"},     o_dt1,     0);
    check_eq({tag, "_dt2"},     o_dt2,     0);
    check_eq({tag, "_overlap"}, o_overlap, 0);
    check_eq({tag, "_stall"},   o_stall,   0);
  endtask

  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_valid", o_valid, 0);
      end else begin
        got = sb_q.pop_front();
        check_eq("valid_latency", cyc,      got.cyc);
        check_eq("period",        o_period, got.period);
        check_eq("t1",            o_t1,     got.t1);
        check_eq("t2",            o_t2,     got.t2);
        check_eq("dt1",           o_dt1,    got.dt1);
        check_eq("dt2",           o_dt2,    got.dt2);
        exp_last = got;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    exp_last = '{default: 0};
    pend     = '{default: 0};
    i_en     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Enabled but no edge yet: stay idle, no stall
    repeat (60) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("idle_stall", o_stall, 0);

    repeat (4) run_period(100, 4, 90, 6, 0);
    check_eq("overlap_clear_before", o_overlap, 0);

    // Overlap: 3 both-high cycles; clear during overlap must lose, later clear wins
    n0 = cyc;
    fork
      run_period(20, 0, 20, 5, 3);
      begin
        wait_cyc(n0 + 23);
        i_clr = 1'b1;
        wait_cyc(n0 + 24);
        i_clr = 1'b0;
        wait_cyc(n0 + 40);
        @(negedge clk);
        check_eq("overlap_sticky", o_overlap, 1);
        i_clr = 1'b1;
        wait_cyc(n0 + 41);
        i_clr = 1'b0;
        @(negedge clk);
        check_eq("overlap_cleared", o_overlap, 0);
      end
    join

    // Stall: long low after a single rise
    n0 = cyc;
    fork
      run_period(5, 2, 3, 100, 0);
      begin
        wait_cyc(n0 + 52);
        @(negedge clk);
        check_eq("stall_before", o_stall, 0);
        wait_cyc(n0 + 53);
        @(negedge clk);
        check_eq("stall_assert", o_stall, 1);
      end
    join
    n0 = cyc;
    fork
      run_period(100, 4, 90, 6, 0);
      begin
        wait_cyc(n0 + 2);
        @(negedge clk);
        check_eq("stall_hold_at_rise", o_stall, 1);
        wait_cyc(n0 + 3);
        @(negedge clk);
        check_eq("stall_release", o_stall, 0);
      end
    join

    // Saturation of t1 and period
    run_period(300, 3, 20, 5, 0);
    run_period(100, 4, 90, 6, 0);

    // Enable drop mid-period: outputs hold, no o_valid
    n0 = cyc;
    fork
      run_period(100, 4, 90, 6, 0);
      begin
        wait_cyc(n0 + 50);
        i_en      = 1'b0;
        have_prev = 1'b0;
      end
    join
    run_period(100, 4, 90, 6, 0);
    run_period(60, 3, 50, 7, 0);
    @(negedge clk);
    check_eq("hold_period", o_period, exp_last.period);
    check_eq("hold_t1",     o_t1,     exp_last.t1);
    check_eq("hold_t2",     o_t2,     exp_last.t2);
    check_eq("hold_dt1",    o_dt1,    exp_last.dt1);
    check_eq("hold_dt2",    o_dt2,    exp_last.dt2);
    check_eq("hold_stall",  o_stall,  0);
    @(posedge clk);
    #1;
    i_en = 1'b1;
    run_period(80, 5, 70, 9, 0);
    run_period(100, 4, 90, 6, 0);

    // Asynchronous reset during the c2-high phase
    n0 = cyc;
    fork
      run_period(100, 4, 90, 6, 0);
      begin
        wait_cyc(n0 + 150);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        wait_cyc(n0 + 153);
        rst_n     = 1'b1;
        have_prev = 1'b0;
        exp_last  = '{default: 0};
      end
    join
    run_period(100, 4, 90, 6, 0);
    run_period(30, 2, 25, 3, 0);
    run_period(100, 4, 90, 6, 0);

    repeat (10) @(posedge clk);
    #1;
    check_eq("scoreboard_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_gate_monitor.md
# pwm_gate_monitor

Measures the complementary gate pair produced by the open-loop dead-time PWM generator and reports the actual timing of each switching period: period, high time of each phase, and both dead times. It sits on the 200 MHz clock domain beside the generator, taps c1/c2 (or their pin loopback), and flags shoot-through (both high) and loss of switching. It provides closed-loop visibility for tuning the switch-selected duty and dead-time settings.

## Interface
- CW, 16, width of all measurement counters and outputs
- TIMEOUT, 65535, cycles without a c1 rising edge before stall is flagged
- clk  in  1  sampling clock (200 MHz PLL output)
- rst  in  1  asynchronous, active-low reset
- i_en  in  1  measurement enable
- i_c1  in  1  high-side gate signal, may be asynchronous
- i_c2  in  1  low-side gate signal, may be asynchronous
- i_clr  in  1  clears sticky o_overlap
- o_valid  out  1  one-cycle pulse: new measurement set latched
- o_period  out  CW  cycles between consecutive c1 rising edges
- o_t1  out  CW  cycles c1 high within the period
- o_t2  out  CW  cycles c2 high within the period
- o_dt1  out  CW  both-low cycles ending in a c1 rise (c2 fall -> c1 rise)
- o_dt2  out  CW  both-low cycles ending in a c2 rise (c1 fall -> c2 rise)
- o_overlap  out  1  sticky: c1 and c2 observed high in the same cycle
- o_stall  out  1  no c1 rising edge for TIMEOUT cycles while enabled

## Operation
- Two-flop synchronizer on each of i_c1 and i_c2 (s1, s2), plus one previous-sample register for edge detection. All logic below uses the synchronized s2 values.
- FSM states: IDLE and RUN.
  - IDLE: accumulators cleared. On a c1 rise with i_en=1, go to RUN. No o_valid is produced.
  - RUN: every cycle, increment period_acc. Increment t1_acc if c1=1 and t2_acc if c2=1. Increment low_cnt if both are 0.
  - c2 rise: dt2_acc <= low_cnt, low_cnt <= 0.
  - c1 rise: dt1 value = low_cnt. Latch period_acc, t1_acc, t2_acc, dt1 value and dt2_acc into the outputs and pulse o_valid. Restart all accumulators, counting the rising cycle as cycle 1 of the new period (period_acc=1, t1_acc=1).
- Both rising in the same cycle: dt1 and dt2 both take low_cnt, the period closes normally, and overlap is set.
- All accumulators and low_cnt saturate at 2^CW-1. They never wrap.
- o_overlap: set in any cycle with c1=c2=1 while i_en=1. Cleared by i_clr=1. Set takes priority over simultaneous clear. Not cleared by i_en.
- o_stall: a stall counter increments each enabled cycle and resets on c1 rise. o_stall=1 while the count is >= TIMEOUT. It clears on the cycle after the next c1 rise. Stays 0 in IDLE before the first edge.
- i_en=0: FSM returns to IDLE and the accumulators and stall counter clear. Measurement outputs hold their last values. o_valid stays 0.

## Timing
- Reset (rst=0, asynchronous): all outputs 0, FSM in IDLE, synchronizers 0.
- Latency: with E0 as the first clk edge sampling i_c1=1, the c1 rise is detected after E1 and o_valid plus the new outputs are registered at E2. o_valid is high for exactly one cycle, E2 to E3.
- Measurement outputs change only on the edge that raises o_valid.
- Pulses shorter than one clk period may be missed. This is acceptable.
- Reset mid-period discards the partial period. The first o_valid after reset requires two c1 rises.

## Test plan
- Periodic waveform: c1 high 100, both low 4, c2 high 90, both low 6, repeated. The second and every later c1 rise give o_valid with period=200, t1=100, t2=90, dt1=6, dt2=4. The first c1 rise gives no o_valid.
- Latency and reset: check that o_valid is a single-cycle pulse exactly 2 edges after the sampling edge. Assert rst at mid-period; all outputs must go to 0 immediately. After release, there is no o_valid until the second c1 rise.
- Overlap: drive c1 and c2 both high for 3 cycles within a period, so o_overlap=1 and remains set. Pulse i_clr during an overlap cycle: o_overlap stays 1. Pulse i_clr afterwards: o_overlap goes to 0.
- Stall: set TIMEOUT=50 and hold c1=0 after one rise. o_stall asserts at count 50. The next c1 rise clears it on the following cycle.
- Saturation: set CW=8 with c1 high for 300 cycles. The next o_valid reports t1=255 and period=255.
- Enable: deassert i_en mid-period. o_valid never asserts and the outputs hold. On re-enable, the first c1 rise gives no o_valid and the second c1 rise reports a full period.
